rv32m_muldiv_unit: RTL and testbench
====================================

Name: rv32m_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit; sits directly downstream of the register file.
- Consumes the two source-operand read values (RD1/RD2) and funct3.
- Produces a 32-bit write-back value destined for the register file write-data port (WD3).
- The control path stalls the core while `busy` is high and asserts WE3 on `done`.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must be able to hold XLEN.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  32  operand A (register file RD1)
rs2_data  input  32  operand B (register file RD2)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid in that cycle
result  output  32  registered result; holds until the next completion

Behaviour:
- Reset (synchronous, active-high): on any edge with rst=1, state=IDLE, busy=0, done=0, result=0, internal regs cleared; rst overrides start.
- Reset mid-operation aborts the operation with no done pulse. The first start accepted is in the cycle after rst deasserts.
- States: IDLE, RUN, FIX, DONE.
- IDLE: if start=1 at edge N, capture funct3, rs1_data and rs2_data. Later operand changes are ignored.
  - Normal case: go to RUN with count=0.
  - Special case (divide by zero, or signed overflow 0x80000000 / 0xFFFFFFFF on DIV/REM): go directly to FIX.
- RUN: one iteration per edge, 32 iterations (edges N+1..N+32). At edge N+32, go to FIX.
  - Multiply: unsigned shift-add of magnitudes into a 64-bit product.
  - Divide: restoring division of magnitudes producing a 32-bit quotient and remainder.
- FIX: one edge applies sign correction, selects the output and registers result, then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: normal ops have done high in the cycle after edge N+33. Special cases have done high in the cycle after edge N+1.
- start while busy=1 is ignored with no queueing. start in the DONE cycle is also ignored.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitudes use two's-complement negation when the sign bit is set and the operand is signed.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32], after negating the full 64-bit product when the operand signs differ.
  - Quotient: negated if the signed operand signs differ.
  - Remainder: takes the dividend's sign.
- Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend unchanged.
- Overflow: DIV gives 0x80000000; REM gives 0.
- Multiplying by zero takes the normal path with no early-out, so latency is constant.
- No exceptions are raised. Arithmetic wraps modulo 2^32.

Test Plan:
- Latency/MUL: reset, then start MUL rs1=7, rs2=0xFFFFFFFD (-3). Expect result=0xFFFFFFEB; done pulse exactly 34 cycles after the start edge; busy high throughout, low after.
- High products:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
- Division signs:
  - DIV 0xFFFFFFF9 (-7) / 2 gives 0xFFFFFFFD.
  - REM gives 0xFFFFFFFF.
  - DIVU 0xFFFFFFFE / 2 gives 0x7FFFFFFF.
  - REMU 100 / 7 gives 2.
- Divide by zero: DIVU 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5. Each has done 2 cycles after start.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 and REM gives 0, fast path of 2 cycles.
- Robustness:
  - Change the operand inputs and pulse start while busy. Expect the original result and no second done.
  - Assert rst 10 cycles into a DIV. Expect busy=0, done=0, result=0 on the next cycle and no done pulse.
  - Then MUL 3×4 gives 12.

Source files
------------

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps
// over operand magnitudes, followed by one sign-fix/select edge.
module rv32m_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  state_t state, state_nxt;

  logic [2:0]       op;
  logic [XLEN-1:0]  hi, lo, bmag;
  logic             neg_q, neg_r, special;
  logic [CNT_W-1:0] count;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic            a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, is_special;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    a_signed   = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    b_signed   = (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
    a_neg      = a_signed & rs1_data[XLEN-1];
    b_neg      = b_signed & rs2_data[XLEN-1];
    div_zero   = funct3[2] && (rs2_data == '0);
    div_ovf    = funct3[2] && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
    is_special = div_zero | div_ovf;
    // Fast-path answers are parked in hi and passed straight through at FIX.
    if (div_zero) spec_val = funct3[1] ? rs1_data : ALL_ONES;
    else          spec_val = funct3[1] ? '0 : MIN_NEG;
  end

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? bmag : '0)};
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, bmag});
    div_diff  = div_shift - {1'b0, bmag};
    prod      = cond_neg2({hi, lo}, neg_q);
    quo       = cond_neg(lo, neg_q);
    rem       = cond_neg(hi, neg_r);
    if (special)      fix_val = hi;
    else if (op[2])   fix_val = op[1] ? rem : quo;
    else if (op[1:0] == 2'b00) fix_val = prod[XLEN-1:0];
    else              fix_val = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = is_special ? FIX : RUN;
      RUN:  if (count == LAST_IT) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // hi:lo is the product during multiply and remainder:quotient during divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0; hi <= '0; lo <= '0; bmag <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; special <= 1'b0;
      count <= '0; result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          lo      <= cond_neg(rs1_data, a_neg);
          bmag    <= cond_neg(rs2_data, b_neg);
          hi      <= is_special ? spec_val : '0;
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          special <= is_special;
          count   <= '0;
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (op[2]) begin
            hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        FIX: result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: driver queues expected result and
// completion cycle; a negedge monitor pops and compares on every done pulse.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, result;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32m_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_latency"}, cyc, e.at);
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] res, input int lat);
    exp_t e;
    e.res  = res;
    e.at   = cyc + lat;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    bit busy_ok;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
    @(posedge clk); #1;
    push_exp(name, exp, lat);
    start = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({name, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check({name, "_idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul_7_m3",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh_min_min",  3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 33);
    run_op("mulhu_max",     3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu_m1_max", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("div_m7_2",      3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_m7_2",      3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
    run_op("divu_fffe_2",   3'b101, 32'hFFFFFFFE,   32'd2,        32'h7FFFFFFF, 33);
    run_op("remu_100_7",    3'b111, 32'd100,        32'd7,        32'd2,        33);
    run_op("divu_by_zero",  3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by_zero",   3'b110, 32'd5,          32'd0,        32'd5,        1);
    run_op("div_overflow",  3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_overflow",  3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);
    run_op("mul_by_zero",   3'b000, 32'd0,          32'h12345678, 32'd0,        33);

    // Operand changes and a second start while busy must not disturb the op.
    @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    push_exp("divu_busy_start", 32'd14, 33);
    start = 1'b0;
    repeat (5) @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = 32'd1; rs2_data = 32'd1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; start = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("done_cycle_start_ignored", {31'b0, busy}, 32'd0);

    // Reset partway through a divide aborts it silently.
    @(negedge clk);
    funct3 = 3'b100; rs1_data = 32'hFFFFFFF9; rs2_data = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    push_exp("div_aborted", 32'hFFFFFFFD, 33);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset_stays_idle", {31'b0, busy}, 32'd0);

    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
